// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: FSM states, owner codes
// and the widths of the latency and starvation counters.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, D requester and memory port signals.
// Handshake: a requester raises *_req with its address/data stable and keeps them until the
// cycle it sees *_gnt high; *_rvalid is a one-cycle pulse with *_rdata valid in that cycle only.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic [3:0]    d_wmask;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          stall;

  modport slave (
    input  if_req, if_addr, d_req, d_wmask, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_wmask, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// Combinational grant selection: D wins unless IF has waited through STARVE_MAX
// consecutive D grants, in which case IF is forced through.
module mem_port_arbiter_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                win_i,
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                if_gnt_o,
  output logic                d_gnt_o,
  output owner_e              sel_o
);

  logic starve_hit;

  assign starve_hit = (starve_cnt_i == STARVE_W'(STARVE_MAX));
  assign if_gnt_o   = win_i && if_req_i && (!d_req_i || starve_hit);
  assign d_gnt_o    = win_i && d_req_i && !if_gnt_o;
  assign sel_o      = if_gnt_o ? OWN_IF : OWN_D;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the
// load/store path; tracks the outstanding read and routes its data to the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_MAX   = 4
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_arbiter_if.slave bus,
  output arb_state_e state_o
);

  arb_state_e          state_q, state_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic   rvalid, win, if_gnt, d_gnt, new_read;
  owner_e sel;
  logic   unused_addr_lsbs;

  // The rvalid cycle doubles as a grant slot so reads can issue back to back.
  assign rvalid = rst && (state_q == ARB_WAIT) && (lat_cnt_q == LAT_W'(1));
  assign win    = rst && ((state_q == ARB_IDLE) || rvalid);

  mem_port_arbiter_select #(.STARVE_MAX(STARVE_MAX)) u_select (
    .win_i        (win),
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
    .starve_cnt_i (starve_cnt_q),
    .if_gnt_o     (if_gnt),
    .d_gnt_o      (d_gnt),
    .sel_o        (sel)
  );

  assign new_read = if_gnt || (d_gnt && (bus.d_wmask == 4'b0000));

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;

    if (!bus.if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end

    if (new_read) begin
      state_d   = ARB_WAIT;
      lat_cnt_d = LAT_W'(READ_LATENCY);
      owner_d   = sel;
    end else if (state_q == ARB_WAIT) begin
      if (lat_cnt_q <= LAT_W'(1)) begin
        state_d   = ARB_IDLE;
        lat_cnt_d = '0;
      end else begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      lat_cnt_q    <= '0;
      owner_q      <= OWN_IF;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.stall     = rst && bus.if_req && !if_gnt;

  assign bus.mem_en    = if_gnt || d_gnt;
  assign bus.mem_we    = d_gnt ? bus.d_wmask : 4'b0000;
  assign bus.mem_wdata = d_gnt ? bus.d_wdata : 32'h0;
  assign bus.mem_addr  = d_gnt  ? bus.d_addr[AW-1:2] :
                         if_gnt ? bus.if_addr[AW-1:2] : '0;

  assign bus.if_rvalid = rvalid && (owner_q == OWN_IF);
  assign bus.d_rvalid  = rvalid && (owner_q == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : 32'h0;

  // Sub-word offset belongs to the load/store unit; the port is word addressed.
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  assign state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at read latencies 1, 2 and 3
// share clock and reset; each step drives inputs just after a rising edge and checks.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  mem_port_arbiter_if #(.AW(32)) b1 ();
  mem_port_arbiter_if #(.AW(32)) b2 ();
  mem_port_arbiter_if #(.AW(32)) b3 ();
  arb_state_e st1, st2, st3;

  mem_port_arbiter #(.AW(32), .READ_LATENCY(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .state_o(st1));
  mem_port_arbiter #(.AW(32), .READ_LATENCY(2), .STARVE_MAX(4)) u2 (
    .clk(clk), .rst(rst), .bus(b2), .state_o(st2));
  mem_port_arbiter #(.AW(32), .READ_LATENCY(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst(rst), .bus(b3), .state_o(st3));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_all();
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_wmask = '0; b1.d_addr = '0;
    b1.d_wdata = '0; b1.mem_rdata = '0;
    b2.if_req = 0; b2.if_addr = '0; b2.d_req = 0; b2.d_wmask = '0; b2.d_addr = '0;
    b2.d_wdata = '0; b2.mem_rdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_wmask = '0; b3.d_addr = '0;
    b3.d_wdata = '0; b3.mem_rdata = '0;
  endtask

  initial begin
    logic [3:0]  wmask_tab [3];
    logic [31:0] waddr_tab [3];
    bit          exp_if;

    wmask_tab[0] = 4'b1111; wmask_tab[1] = 4'b0011; wmask_tab[2] = 4'b1000;
    waddr_tab[0] = 32'h200; waddr_tab[1] = 32'h204; waddr_tab[2] = 32'h208;

    rst = 1'b0;
    clear_all();

    // reset: requests asserted must not produce grants or stall
    next_cycle();
    b1.if_req = 1; b1.d_req = 1; b1.mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rst_if_gnt", b1.if_gnt, 0);
    chk("rst_d_gnt", b1.d_gnt, 0);
    chk("rst_mem_en", b1.mem_en, 0);
    chk("rst_mem_we", b1.mem_we, 0);
    chk("rst_stall", b1.stall, 0);
    chk("rst_rdata", {b1.if_rdata, b1.d_rdata}, 0);
    chk("rst_state", st1, ARB_IDLE);
    next_cycle();
    clear_all();
    rst = 1'b1;
    next_cycle();

    // single IF read, latency 2
    b2.if_req = 1; b2.if_addr = 32'h4000_0010;
    settle();
    chk("l2_if_gnt", b2.if_gnt, 1);
    chk("l2_mem_en", b2.mem_en, 1);
    chk("l2_mem_addr", b2.mem_addr, 30'h1000_0004);
    chk("l2_mem_we", b2.mem_we, 0);
    chk("l2_stall0", b2.stall, 0);
    next_cycle();
    b2.if_req = 0;
    settle();
    chk("l2_c1_rvalid", b2.if_rvalid, 0);
    chk("l2_c1_state", st2, ARB_WAIT);
    chk("l2_c1_mem_en", b2.mem_en, 0);
    next_cycle();
    b2.mem_rdata = 32'hCAFE_0001;
    settle();
    chk("l2_c2_rvalid", b2.if_rvalid, 1);
    chk("l2_c2_rdata", b2.if_rdata, 32'hCAFE_0001);
    chk("l2_c2_d_rvalid", b2.d_rvalid, 0);
    next_cycle();
    settle();
    chk("l2_c3_rvalid", b2.if_rvalid, 0);
    chk("l2_c3_state", st2, ARB_IDLE);

    // starvation: both read continuously, latency 1 -> D,D,D,D,IF repeating
    b1.if_req = 1; b1.if_addr = 32'h1000; b1.d_req = 1; b1.d_wmask = 0; b1.d_addr = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      settle();
      exp_if = (i % 5 == 4);
      chk($sformatf("sv_if_gnt_%0d", i), b1.if_gnt, exp_if);
      chk($sformatf("sv_d_gnt_%0d", i), b1.d_gnt, !exp_if);
      chk($sformatf("sv_stall_%0d", i), b1.stall, !exp_if);
      chk($sformatf("sv_mem_addr_%0d", i), b1.mem_addr, exp_if ? 30'h400 : 30'h800);
      if (i > 0) begin
        chk($sformatf("sv_if_rv_%0d", i), b1.if_rvalid, ((i - 1) % 5 == 4));
        chk($sformatf("sv_d_rv_%0d", i), b1.d_rvalid, ((i - 1) % 5 != 4));
      end
      next_cycle();
    end
    b1.if_req = 0; b1.d_req = 0;
    settle();
    chk("sv_tail_if_rv", b1.if_rvalid, 1);
    chk("sv_tail_d_rv", b1.d_rvalid, 0);
    chk("sv_tail_gnt", {b1.if_gnt, b1.d_gnt}, 0);
    next_cycle();
    settle();
    chk("sv_tail_state", st1, ARB_IDLE);

    // three back-to-back D writes with IF waiting
    b1.if_req = 1; b1.if_addr = 32'h3000; b1.d_req = 1;
    for (int i = 0; i < 3; i++) begin
      b1.d_wmask = wmask_tab[i]; b1.d_addr = waddr_tab[i]; b1.d_wdata = 32'hA000_0000 + i;
      settle();
      chk($sformatf("wr_d_gnt_%0d", i), b1.d_gnt, 1);
      chk($sformatf("wr_if_gnt_%0d", i), b1.if_gnt, 0);
      chk($sformatf("wr_mem_we_%0d", i), b1.mem_we, wmask_tab[i]);
      chk($sformatf("wr_mem_addr_%0d", i), b1.mem_addr, 30'h80 + i);
      chk($sformatf("wr_mem_wdata_%0d", i), b1.mem_wdata, 32'hA000_0000 + i);
      chk($sformatf("wr_stall_%0d", i), b1.stall, 1);
      chk($sformatf("wr_d_rv_%0d", i), b1.d_rvalid, 0);
      chk($sformatf("wr_state_%0d", i), st1, ARB_IDLE);
      next_cycle();
    end
    b1.d_req = 0; b1.d_wmask = 0;
    settle();
    chk("wr_if_gnt_after", b1.if_gnt, 1);
    chk("wr_d_rv_after", b1.d_rvalid, 0);
    chk("wr_mem_addr_after", b1.mem_addr, 30'hC00);
    next_cycle();
    b1.if_req = 0;
    settle();
    chk("wr_if_rv_after", b1.if_rvalid, 1);
    next_cycle();

    // latency 3: IF read, D read waits and is granted with if_rvalid
    b3.if_req = 1; b3.if_addr = 32'h40;
    settle();
    chk("l3_c0_if_gnt", b3.if_gnt, 1);
    next_cycle();
    b3.if_req = 0; b3.d_req = 1; b3.d_wmask = 0; b3.d_addr = 32'h100;
    settle();
    chk("l3_c1_d_gnt", b3.d_gnt, 0);
    chk("l3_c1_mem_en", b3.mem_en, 0);
    next_cycle();
    settle();
    chk("l3_c2_d_gnt", b3.d_gnt, 0);
    chk("l3_c2_mem_en", b3.mem_en, 0);
    next_cycle();
    b3.mem_rdata = 32'h1111_1111;
    settle();
    chk("l3_c3_d_gnt", b3.d_gnt, 1);
    chk("l3_c3_if_rv", b3.if_rvalid, 1);
    chk("l3_c3_if_rdata", b3.if_rdata, 32'h1111_1111);
    chk("l3_c3_mem_addr", b3.mem_addr, 30'h40);
    next_cycle();
    b3.d_req = 0; b3.mem_rdata = 0;
    settle();
    chk("l3_c4_gnt", {b3.if_gnt, b3.d_gnt}, 0);
    chk("l3_c4_rv", {b3.if_rvalid, b3.d_rvalid}, 0);
    next_cycle();
    settle();
    chk("l3_c5_d_rv", b3.d_rvalid, 0);
    next_cycle();
    b3.mem_rdata = 32'h2222_2222;
    settle();
    chk("l3_c6_d_rv", b3.d_rvalid, 1);
    chk("l3_c6_d_rdata", b3.d_rdata, 32'h2222_2222);
    chk("l3_c6_if_rv", b3.if_rvalid, 0);
    next_cycle();
    settle();
    chk("l3_c7_state", st3, ARB_IDLE);
    chk("l3_c7_d_rv", b3.d_rvalid, 0);

    // latency 3: D request dropped while waiting has no effect
    b3.if_req = 1; b3.if_addr = 32'h80;
    settle();
    chk("dr_c0_if_gnt", b3.if_gnt, 1);
    next_cycle();
    b3.if_req = 0; b3.d_req = 1; b3.d_addr = 32'h300;
    settle();
    chk("dr_c1_mem_en", b3.mem_en, 0);
    next_cycle();
    b3.d_req = 0;
    settle();
    chk("dr_c2_mem_en", b3.mem_en, 0);
    next_cycle();
    b3.mem_rdata = 32'h3333_3333;
    settle();
    chk("dr_c3_if_rv", b3.if_rvalid, 1);
    chk("dr_c3_d_gnt", b3.d_gnt, 0);
    chk("dr_c3_mem_en", b3.mem_en, 0);
    next_cycle();
    settle();
    chk("dr_c4_state", st3, ARB_IDLE);
    chk("dr_c4_rv", {b3.if_rvalid, b3.d_rvalid}, 0);

    // reset in the cycle after a D read grant drops the read
    b1.d_req = 1; b1.d_wmask = 0; b1.d_addr = 32'h100;
    settle();
    chk("mr_c0_d_gnt", b1.d_gnt, 1);
    next_cycle();
    b1.d_req = 0; b1.mem_rdata = 32'h5555_5555; rst = 1'b0;
    settle();
    chk("mr_c1_d_rv", b1.d_rvalid, 0);
    chk("mr_c1_d_rdata", b1.d_rdata, 0);
    chk("mr_c1_mem_en", b1.mem_en, 0);
    chk("mr_c1_stall", b1.stall, 0);
    next_cycle();
    rst = 1'b1;
    settle();
    chk("mr_c2_state", st1, ARB_IDLE);
    chk("mr_c2_d_rv", b1.d_rvalid, 0);
    next_cycle();
    settle();
    chk("mr_c3_d_rv", b1.d_rvalid, 0);
    chk("mr_c3_mem_en", b1.mem_en, 0);

    // final report
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
